// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (LEN_LO, LEN_HI, payload, CHK)
// from the host, writes the payload into instruction memory and holds the MISC
// core in reset until the image is complete and its XOR checksum verifies.
module program_loader #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_data,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_error
);

    // Length compare width: wide enough for both a 16-bit length and 2**ADDR_W.
    localparam int LEN_W = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'({1'b1, {ADDR_W{1'b0}}});

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_ready;
    logic                w_xfer;

    logic [7:0]          r_len_lo;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_addr;
    logic [7:0]          r_acc;

    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [INSTR_W-1:0]  r_wdata;

    logic                r_cpu_reset;
    logic                r_load_done;
    logic                r_load_error;

    logic [LEN_W-1:0]    w_len_full;
    logic [ADDR_W:0]     w_addr_inc;
    logic                w_last;

    // Full frame length as it becomes known while the LEN_HI byte is on the bus.
    assign w_len_full = LEN_W'({in_data, r_len_lo});
    // The counter is one bit wider than the address so N = 2**ADDR_W never wraps.
    assign w_addr_inc = r_addr + (ADDR_W+1)'(1);
    assign w_last     = (w_addr_inc == r_len);
    assign w_xfer     = in_valid & w_ready;

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_waddr;
    assign imem_data  = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; in_ready depends on state only.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_LEN_LO: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    if (w_len_full == '0) begin
                        w_next = S_CHECK;
                    end else if (w_len_full > MAX_LEN) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                w_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_next = (in_data == r_acc) ? S_RUN : S_ERROR;
                end
            end
            S_RUN: begin
                if (reload) begin
                    w_next = S_LEN_LO;
                end
            end
            S_ERROR: begin
                if (reload) begin
                    w_next = S_LEN_LO;
                end
            end
            default: begin
                w_next = S_LEN_LO;
            end
        endcase
    end

    // Length capture, address/checksum tracking and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_addr   <= '0;
            r_acc    <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    S_LEN_LO: begin
                        r_len_lo <= in_data;
                    end
                    S_LEN_HI: begin
                        // Upper bits only matter for lengths that go to ERROR.
                        r_len  <= w_len_full[ADDR_W:0];
                        r_addr <= '0;
                        r_acc  <= '0;
                    end
                    S_DATA: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr[ADDR_W-1:0];
                        r_wdata <= in_data[INSTR_W-1:0];
                        r_acc   <= r_acc ^ in_data;
                        r_addr  <= w_addr_inc;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Core reset and status flags, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_cpu_reset  <= (w_next != S_RUN);
            r_load_done  <= (w_next == S_RUN);
            r_load_error <= (w_next == S_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: two loaders (ADDR_W=16 and ADDR_W=4) driven with directed
// frames; a frame-level byte model predicts every output each cycle.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] t_data[2]   = '{8'h00, 8'h00};
    logic       t_valid[2]  = '{1'b0, 1'b0};
    logic       t_reload[2] = '{1'b0, 1'b0};

    logic        d0_ready, d0_we, d0_crst, d0_done, d0_err;
    logic [15:0] d0_addr;
    logic [7:0]  d0_wdata;
    logic        d1_ready, d1_we, d1_crst, d1_done, d1_err;
    logic [3:0]  d1_addr;
    logic [7:0]  d1_wdata;

    int n_vec  = 0;
    int n_fail = 0;

    program_loader #(.ADDR_W(16), .INSTR_W(8)) dut0 (
        .clk(clk), .reset(rst), .in_data(t_data[0]), .in_valid(t_valid[0]),
        .in_ready(d0_ready), .reload(t_reload[0]), .imem_we(d0_we),
        .imem_addr(d0_addr), .imem_data(d0_wdata), .cpu_reset(d0_crst),
        .load_done(d0_done), .load_error(d0_err)
    );

    program_loader #(.ADDR_W(4), .INSTR_W(8)) dut1 (
        .clk(clk), .reset(rst), .in_data(t_data[1]), .in_valid(t_valid[1]),
        .in_ready(d1_ready), .reload(t_reload[1]), .imem_we(d1_we),
        .imem_addr(d1_addr), .imem_data(d1_wdata), .cpu_reset(d1_crst),
        .load_done(d1_done), .load_error(d1_err)
    );

    always #5 clk = ~clk;

    // Model: st 0 = loading, 1 = running, 2 = error; cnt = bytes taken in this frame.
    int m_max[2]  = '{65536, 16};
    int m_st[2]   = '{0, 0};
    int m_cnt[2]  = '{0, 0};
    int m_lo[2]   = '{0, 0};
    int m_len[2]  = '{0, 0};
    int m_x[2]    = '{0, 0};
    int e_we[2]   = '{0, 0};
    int e_addr[2] = '{0, 0};
    int e_data[2] = '{0, 0};
    int e_crst[2] = '{1, 1};
    int e_done[2] = '{0, 0};
    int e_err[2]  = '{0, 0};

    int wlog0[$];
    int wlog1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int b;
        b = int'(t_data[d]);
        e_we[d] = 0;
        if (m_st[d] == 0) begin
            if (t_valid[d]) begin
                if (m_cnt[d] == 0) begin
                    m_lo[d]  = b;
                    m_cnt[d] = 1;
                end else if (m_cnt[d] == 1) begin
                    m_len[d] = b * 256 + m_lo[d];
                    m_cnt[d] = 2;
                    m_x[d]   = 0;
                    if (m_len[d] > m_max[d]) m_st[d] = 2;
                end else if (m_cnt[d] - 2 < m_len[d]) begin
                    e_we[d]   = 1;
                    e_addr[d] = m_cnt[d] - 2;
                    e_data[d] = b;
                    m_x[d]    = m_x[d] ^ b;
                    m_cnt[d]++;
                end else begin
                    m_st[d] = (b == m_x[d]) ? 1 : 2;
                end
            end
        end else if (t_reload[d]) begin
            m_st[d]  = 0;
            m_cnt[d] = 0;
        end
        e_crst[d] = (m_st[d] != 1) ? 1 : 0;
        e_done[d] = (m_st[d] == 1) ? 1 : 0;
        e_err[d]  = (m_st[d] == 2) ? 1 : 0;
    endtask

    // Model advances on each clock edge and resets asynchronously.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_st[d] = 0; m_cnt[d] = 0; m_lo[d] = 0; m_len[d] = 0; m_x[d] = 0;
                e_we[d] = 0; e_addr[d] = 0; e_data[d] = 0;
                e_crst[d] = 1; e_done[d] = 0; e_err[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // Compare every output of both loaders against the model mid-cycle.
    always @(negedge clk) begin
        chk("d0_ready", d0_ready, (m_st[0] == 0));
        chk("d0_we",    d0_we,    e_we[0]);
        chk("d0_addr",  d0_addr,  e_addr[0]);
        chk("d0_data",  d0_wdata, e_data[0]);
        chk("d0_crst",  d0_crst,  e_crst[0]);
        chk("d0_done",  d0_done,  e_done[0]);
        chk("d0_err",   d0_err,   e_err[0]);
        chk("d1_ready", d1_ready, (m_st[1] == 0));
        chk("d1_we",    d1_we,    e_we[1]);
        chk("d1_addr",  d1_addr,  e_addr[1]);
        chk("d1_data",  d1_wdata, e_data[1]);
        chk("d1_crst",  d1_crst,  e_crst[1]);
        chk("d1_done",  d1_done,  e_done[1]);
        chk("d1_err",   d1_err,   e_err[1]);
        if (d0_we === 1'b1) wlog0.push_back(int'({d0_addr, d0_wdata}));
        if (d1_we === 1'b1) wlog1.push_back(int'({d1_addr, d1_wdata}));
    end

    task automatic send(input int d, input int b, input int gap, input logic rl);
        int n;
        n = 0;
        while (gap > 0 && n < 3 && $urandom_range(99) < gap) begin
            @(negedge clk);
            t_valid[d]  = 1'b0;
            t_reload[d] = 1'b0;
            t_data[d]   = 8'($urandom);
            n++;
        end
        @(negedge clk);
        t_valid[d]  = 1'b1;
        t_reload[d] = rl;
        t_data[d]   = 8'(b);
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            t_valid[d]  = 1'b0;
            t_reload[d] = 1'b0;
        end
    endtask

    task automatic send_frame(input int d, input int pl[$], input int ck, input int gap);
        send(d, pl.size() % 256, gap, 1'b0);
        send(d, pl.size() / 256, gap, 1'b0);
        foreach (pl[i]) send(d, pl[i], gap, 1'b0);
        send(d, ck, gap, 1'b0);
    endtask

    task automatic pulse_reload(input int d);
        @(negedge clk);
        t_valid[d]  = 1'b0;
        t_reload[d] = 1'b1;
        @(negedge clk);
        t_reload[d] = 1'b0;
    endtask

    initial begin
        int pl[$];
        int ref_log[$];
        int x;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_crst", d0_crst, 1);
        chk("rst_done", d0_done, 0);
        chk("rst_we", d0_we, 0);
        chk("rst_ready", d0_ready, 1);
        rst = 1'b0;
        idle(0, 2);

        // Good 3-byte frame.
        wlog0.delete();
        send_frame(0, '{8'h10, 8'h20, 8'h30}, 8'h00, 0);
        chk("t1_done_at_chk", d0_done, 0);
        idle(0, 1);
        chk("t1_done_after", d0_done, 1);
        chk("t1_crst_after", d0_crst, 0);
        chk("t1_ready_run", d0_ready, 0);
        chk("t1_nwrites", wlog0.size(), 3);
        if (wlog0.size() == 3) begin
            chk("t1_w0", wlog0[0], 32'h0010);
            chk("t1_w1", wlog0[1], 32'h0120);
            chk("t1_w2", wlog0[2], 32'h0230);
        end
        send(0, 8'h77, 0, 1'b0);
        idle(0, 2);
        pulse_reload(0);
        idle(0, 1);
        chk("t1_reload_done", d0_done, 0);
        chk("t1_reload_crst", d0_crst, 1);

        // Bad checksum, then recovery.
        send_frame(0, '{8'hAA, 8'h55}, 8'h00, 0);
        idle(0, 2);
        chk("t2_err", d0_err, 1);
        chk("t2_crst", d0_crst, 1);
        pulse_reload(0);
        chk("t2_err_cleared", d0_err, 0);
        send_frame(0, '{8'h5A}, 8'h5A, 0);
        idle(0, 2);
        chk("t2_recover_done", d0_done, 1);
        pulse_reload(0);

        // Zero-length frames.
        wlog0.delete();
        send_frame(0, pl, 8'h00, 0);
        idle(0, 2);
        chk("t3_zero_done", d0_done, 1);
        chk("t3_zero_nwrites", wlog0.size(), 0);
        pulse_reload(0);
        send_frame(0, pl, 8'h01, 0);
        idle(0, 2);
        chk("t3_zero_badchk", d0_err, 1);
        pulse_reload(0);

        // ADDR_W=4: exact fill, then one byte too many.
        pl.delete();
        x = 0;
        for (int i = 0; i < 16; i++) begin
            pl.push_back((i * 17 + 3) & 8'hFF);
            x = x ^ ((i * 17 + 3) & 8'hFF);
        end
        wlog1.delete();
        send_frame(1, pl, x, 0);
        idle(1, 2);
        chk("t4_full_done", d1_done, 1);
        chk("t4_full_nwrites", wlog1.size(), 16);
        if (wlog1.size() == 16) chk("t4_last_addr", wlog1[15] >> 8, 15);
        pulse_reload(1);
        send(1, 8'h11, 0, 1'b0);
        send(1, 8'h00, 0, 1'b0);
        idle(1, 1);
        chk("t4_over_err", d1_err, 1);
        chk("t4_over_ready", d1_ready, 0);
        pulse_reload(1);

        // 64-byte frame, gapless then with random gaps.
        pl.delete();
        x = 0;
        for (int i = 0; i < 64; i++) begin
            pl.push_back((i * 37 + 5) & 8'hFF);
            x = x ^ ((i * 37 + 5) & 8'hFF);
        end
        wlog0.delete();
        send_frame(0, pl, x, 0);
        idle(0, 2);
        chk("t5_plain_done", d0_done, 1);
        ref_log = wlog0;
        pulse_reload(0);
        wlog0.delete();
        send_frame(0, pl, x, 50);
        idle(0, 2);
        chk("t5_gap_done", d0_done, 1);
        chk("t5_gap_nwrites", wlog0.size(), ref_log.size());
        if (wlog0.size() == ref_log.size()) begin
            foreach (ref_log[i]) chk("t5_gap_seq", wlog0[i], ref_log[i]);
        end
        pulse_reload(0);

        // Reset mid-frame after 5 payload bytes.
        send(0, 8'h08, 0, 1'b0);
        send(0, 8'h00, 0, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 8'hC0 + i, 0, 1'b0);
        @(negedge clk);
        t_valid[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we", d0_we, 0);
        chk("t6_rst_addr", d0_addr, 0);
        chk("t6_rst_data", d0_wdata, 0);
        chk("t6_rst_crst", d0_crst, 1);
        chk("t6_rst_done", d0_done, 0);
        chk("t6_rst_err", d0_err, 0);
        chk("t6_rst_ready", d0_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        idle(0, 1);

        // Fresh frame with reload asserted alongside a payload byte.
        wlog0.delete();
        send(0, 8'h04, 0, 1'b0);
        send(0, 8'h00, 0, 1'b0);
        send(0, 8'h01, 0, 1'b0);
        send(0, 8'h02, 0, 1'b1);
        send(0, 8'h04, 0, 1'b0);
        send(0, 8'h08, 0, 1'b0);
        send(0, 8'h0F, 0, 1'b0);
        idle(0, 2);
        chk("t6_fresh_done", d0_done, 1);
        chk("t6_fresh_nwrites", wlog0.size(), 4);
        if (wlog0.size() == 4) chk("t6_fresh_w1", wlog0[1], 32'h0102);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
